// File: rtl/rx_packet_parser_pkg.sv
// Shared definitions for the rx_packet_parser frame parser: prefix byte,
// default channel count, checksum width, state encoding and error pulse bundle.
package rx_packet_parser_pkg;

  localparam logic [7:0] PREFIX    = 8'hDD;
  localparam int         DEF_N_SRC = 8;
  localparam int         CSUM_W    = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SRC,
    S_DST,
    S_LEN,
    S_PAYLOAD,
    S_CRC,
    S_DRAIN
  } state_t;

  typedef struct packed {
    logic crc;
    logic len;
    logic addr;
    logic drop;
  } err_t;

  // Running checksum is a plain modular byte sum.
  function automatic logic [CSUM_W-1:0] csum_add(input logic [CSUM_W-1:0] acc,
                                                 input logic [7:0]        b);
    return acc + CSUM_W'(b);
  endfunction

endpackage

// File: rtl/rx_packet_parser_pkt_buf.sv
// Payload buffer for rx_packet_parser: DEPTH x 8 synchronous write,
// registered read, intended to map onto block RAM.
module pkt_buf
  import rx_packet_parser_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_ptr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_ptr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem_reg [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_reg[wr_ptr] <= wr_data;
    end
    rd_data <= mem_reg[rd_ptr];
  end

endmodule

// File: rtl/rx_packet_parser.sv
// Frame parser: DD src dst len payload sum; payload released to channel dst
// only after the checksum verifies. Optional idle timeout: PARSER_TIMEOUT_EN.
module rx_packet_parser
  import rx_packet_parser_pkg::*;
#(
  parameter int N_SRC       = DEF_N_SRC,
  parameter int MAX_LEN     = 32,
  parameter int TIMEOUT_CYC = 48000
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  input  logic [N_SRC-1:0] dest_ready,
  output logic [7:0]       master_data,
  output logic [N_SRC-1:0] valid_bus,
  output logic [7:0]       src_addr,
  output logic             busy,
  output logic             crc_err,
  output logic             len_err,
  output logic             addr_err,
  output logic             drop_err,
  output logic             tmo_err
);

  localparam int         AW       = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [8:0] MAX_LEN9 = 9'(MAX_LEN);
  localparam logic [8:0] N_SRC9   = 9'(N_SRC);

  state_t              state_reg, state_next;
  logic [7:0]          src_shadow_reg, src_shadow_next;
  logic [7:0]          dst_reg, dst_next;
  logic [7:0]          len_reg, len_next;
  logic [CSUM_W-1:0]   sum_reg, sum_next;
  logic [AW-1:0]       wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0]       rd_ptr_reg, rd_ptr_next;
  logic [1:0]          fill_reg, fill_next;
  logic [7:0]          master_data_reg, master_data_next;
  logic [N_SRC-1:0]    valid_bus_reg, valid_bus_next;
  logic [7:0]          src_addr_reg, src_addr_next;
  err_t                err_reg, err_next;

  logic                buf_wr_en;
  logic [AW-1:0]       buf_rd_ptr;
  logic [7:0]          buf_rd_data;
  logic [N_SRC-1:0]    dst_hit;
  logic                dst_ok;
  logic                xfer;
  logic                tmo_hit;

  genvar gi;
  generate
    for (gi = 0; gi < N_SRC; gi++) begin : g_dst
      assign dst_hit[gi] = ({1'b0, dst_reg} == 9'(gi));
    end
  endgenerate

  assign dst_ok = ({1'b0, dst_reg} < N_SRC9);
  // fill_reg == 2 means the output register holds a byte on offer.
  assign xfer   = (fill_reg == 2'd2) && (|(valid_bus_reg & dest_ready));

  pkt_buf #(
    .DEPTH (MAX_LEN),
    .AW    (AW)
  ) u_buf (
    .clk     (clk),
    .wr_en   (buf_wr_en),
    .wr_ptr  (wr_ptr_reg),
    .wr_data (rx_data),
    .rd_ptr  (buf_rd_ptr),
    .rd_data (buf_rd_data)
  );

`ifdef PARSER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] idle_cnt_reg;
  logic          timed;
  logic          tmo_err_reg;

  assign timed   = (state_reg != S_IDLE) && (state_reg != S_DRAIN);
  assign tmo_hit = timed && !rx_valid && (idle_cnt_reg == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      idle_cnt_reg <= '0;
      tmo_err_reg  <= 1'b0;
    end else begin
      tmo_err_reg <= tmo_hit;
      if (!timed || rx_valid || tmo_hit) begin
        idle_cnt_reg <= '0;
      end else begin
        idle_cnt_reg <= idle_cnt_reg + TW'(1);
      end
    end
  end

  assign tmo_err = tmo_err_reg;
`else
  // The timeout limit has no consumer when the counter is not built.
  logic [31:0] unused_tmo_cfg;
  assign unused_tmo_cfg = 32'(TIMEOUT_CYC);
  assign tmo_hit        = 1'b0;
  assign tmo_err        = 1'b0;
`endif

  always_comb begin
    state_next       = state_reg;
    src_shadow_next  = src_shadow_reg;
    dst_next         = dst_reg;
    len_next         = len_reg;
    sum_next         = sum_reg;
    wr_ptr_next      = wr_ptr_reg;
    rd_ptr_next      = rd_ptr_reg;
    fill_next        = fill_reg;
    master_data_next = master_data_reg;
    valid_bus_next   = valid_bus_reg;
    src_addr_next    = src_addr_reg;
    err_next         = '0;
    buf_wr_en        = 1'b0;
    buf_rd_ptr       = rd_ptr_reg;

    case (state_reg)
      S_IDLE: begin
        if (rx_valid && (rx_data == PREFIX)) begin
          state_next = S_SRC;
        end
      end
      S_SRC: begin
        if (rx_valid) begin
          src_shadow_next = rx_data;
          sum_next        = csum_add('0, rx_data);
          state_next      = S_DST;
        end
      end
      S_DST: begin
        if (rx_valid) begin
          dst_next   = rx_data;
          sum_next   = csum_add(sum_reg, rx_data);
          state_next = S_LEN;
        end
      end
      S_LEN: begin
        if (rx_valid) begin
          len_next = rx_data;
          sum_next = csum_add(sum_reg, rx_data);
          if ({1'b0, rx_data} > MAX_LEN9) begin
            err_next.len = 1'b1;
            state_next   = S_IDLE;
          end else if (rx_data == 8'd0) begin
            state_next = S_CRC;
          end else begin
            wr_ptr_next = '0;
            state_next  = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        if (rx_valid) begin
          buf_wr_en   = 1'b1;
          wr_ptr_next = wr_ptr_reg + AW'(1);
          sum_next    = csum_add(sum_reg, rx_data);
          if (8'(wr_ptr_reg) == (len_reg - 8'd1)) begin
            state_next = S_CRC;
          end
        end
      end
      S_CRC: begin
        if (rx_valid) begin
          state_next = S_IDLE;
          if (CSUM_W'(rx_data) != sum_reg) begin
            err_next.crc = 1'b1;
          end else if (!dst_ok) begin
            err_next.addr = 1'b1;
          end else begin
            src_addr_next = src_shadow_reg;
            if (len_reg != 8'd0) begin
              rd_ptr_next = '0;
              fill_next   = 2'd0;
              state_next  = S_DRAIN;
            end
          end
        end
      end
      S_DRAIN: begin
        err_next.drop = rx_valid;
        // Read port stays one entry ahead of the output register so that
        // back-to-back transfers need no extra bubble.
        case (fill_reg)
          2'd0: begin
            fill_next = 2'd1;
          end
          2'd1: begin
            buf_rd_ptr       = rd_ptr_reg + AW'(1);
            master_data_next = buf_rd_data;
            valid_bus_next   = dst_hit;
            fill_next        = 2'd2;
          end
          default: begin
            if (xfer) begin
              buf_rd_ptr = rd_ptr_reg + AW'(2);
              if (8'(rd_ptr_reg) == (len_reg - 8'd1)) begin
                valid_bus_next = '0;
                state_next     = S_IDLE;
              end else begin
                master_data_next = buf_rd_data;
                rd_ptr_next      = rd_ptr_reg + AW'(1);
              end
            end else begin
              buf_rd_ptr = rd_ptr_reg + AW'(1);
            end
          end
        endcase
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    if (tmo_hit) begin
      state_next = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_reg       <= S_IDLE;
      src_shadow_reg  <= '0;
      dst_reg         <= '0;
      len_reg         <= '0;
      sum_reg         <= '0;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      fill_reg        <= '0;
      master_data_reg <= '0;
      valid_bus_reg   <= '0;
      src_addr_reg    <= '0;
      err_reg         <= '0;
    end else begin
      state_reg       <= state_next;
      src_shadow_reg  <= src_shadow_next;
      dst_reg         <= dst_next;
      len_reg         <= len_next;
      sum_reg         <= sum_next;
      wr_ptr_reg      <= wr_ptr_next;
      rd_ptr_reg      <= rd_ptr_next;
      fill_reg        <= fill_next;
      master_data_reg <= master_data_next;
      valid_bus_reg   <= valid_bus_next;
      src_addr_reg    <= src_addr_next;
      err_reg         <= err_next;
    end
  end

  assign master_data = master_data_reg;
  assign valid_bus   = valid_bus_reg;
  assign src_addr    = src_addr_reg;
  assign busy        = (state_reg != S_IDLE);
  assign crc_err     = err_reg.crc;
  assign len_err     = err_reg.len;
  assign addr_err    = err_reg.addr;
  assign drop_err    = err_reg.drop;

endmodule

// File: tb/tb_rx_packet_parser.sv
// Self-checking bench for rx_packet_parser: directed frames plus random frames
// checked against a frame-level model built from field values.
module tb_rx_packet_parser;
  import rx_packet_parser_pkg::*;

  localparam int N_SRC       = 8;
  localparam int MAX_LEN     = 32;
  localparam int TIMEOUT_CYC = 200;

  logic             clk        = 1'b0;
  logic             n_rst      = 1'b0;
  logic [7:0]       rx_data    = 8'h00;
  logic             rx_valid   = 1'b0;
  logic [N_SRC-1:0] dest_ready = '0;
  logic [7:0]       master_data;
  logic [N_SRC-1:0] valid_bus;
  logic [7:0]       src_addr;
  logic             busy, crc_err, len_err, addr_err, drop_err, tmo_err;

  int n_assert = 0;
  int n_fail   = 0;
  int seen_crc = 0, seen_len = 0, seen_addr = 0, seen_drop = 0, seen_tmo = 0;
  int exp_crc  = 0, exp_len  = 0, exp_addr  = 0, exp_drop  = 0, exp_tmo  = 0;
  logic [7:0] exp_src = 8'h00;
  int gap_max   = 0;
  int inject_at = -1;
  bit rdy_pat[$];

  always #5 clk = ~clk;

  rx_packet_parser #(
    .N_SRC       (N_SRC),
    .MAX_LEN     (MAX_LEN),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .dest_ready  (dest_ready),
    .master_data (master_data),
    .valid_bus   (valid_bus),
    .src_addr    (src_addr),
    .busy        (busy),
    .crc_err     (crc_err),
    .len_err     (len_err),
    .addr_err    (addr_err),
    .drop_err    (drop_err),
    .tmo_err     (tmo_err)
  );

  // Total pulse-cycles per error output, compared against the model at the end.
  always @(negedge clk) begin
    if (n_rst) begin
      if (crc_err)  seen_crc++;
      if (len_err)  seen_len++;
      if (addr_err) seen_addr++;
      if (drop_err) seen_drop++;
      if (tmo_err)  seen_tmo++;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: observed no end of test, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
  endtask

  task automatic gap();
    if (gap_max > 0) repeat ($urandom_range(32'(gap_max))) step();
  endtask

  task automatic drain(input logic [7:0] dst, input logic [7:0] pl[$], input int ready_pct);
    logic [N_SRC-1:0] oh;
    int idx, cyc;
    bit rdy, injected;
    oh = N_SRC'(1) << dst;
    check("lat_k_valid", 32'(valid_bus), 0);
    step();
    check("lat_k1_valid", 32'(valid_bus), 0);
    step();
    idx = 0;
    cyc = 0;
    injected = 1'b0;
    while (idx < pl.size() && cyc < 8 * pl.size() + 64) begin
      check("drain_valid", 32'(valid_bus), 32'(oh));
      check("drain_data", 32'(master_data), 32'(pl[idx]));
      if (cyc < rdy_pat.size()) rdy = rdy_pat[cyc];
      else rdy = ($urandom_range(99) < 32'(ready_pct));
      dest_ready = N_SRC'($urandom);
      dest_ready = rdy ? (dest_ready | oh) : (dest_ready & ~oh);
      if (cyc == inject_at) begin
        rx_data  = PREFIX;
        rx_valid = 1'b1;
        injected = 1'b1;
      end
      step();
      if (injected) begin
        rx_valid = 1'b0;
        injected = 1'b0;
        exp_drop++;
        check("drop_err", 32'(drop_err), 1);
      end
      if (rdy) idx++;
      cyc++;
    end
    check("drain_count", 32'(idx), 32'(pl.size()));
    if (ready_pct == 100 && rdy_pat.size() == 0) check("b2b_cycles", 32'(cyc), 32'(pl.size()));
    check("drain_end_valid", 32'(valid_bus), 0);
    check("drain_end_busy", 32'(busy), 0);
    dest_ready = '0;
  endtask

  // Frame-level model: the outcome follows from the field values alone.
  task automatic run_frame(input logic [7:0] src, input logic [7:0] dst, input logic [7:0] len,
                           input logic [7:0] pl[$], input logic [7:0] crc_delta, input int ready_pct);
    logic [7:0] sum;
    logic [7:0] junk;
    sum = src + dst + len;
    foreach (pl[i]) sum = sum + pl[i];
    send_byte(PREFIX);
    check("busy_after_prefix", 32'(busy), 1);
    gap(); send_byte(src);
    gap(); send_byte(dst);
    gap(); send_byte(len);
    if (int'(len) > MAX_LEN) begin
      exp_len++;
      check("len_err", 32'(len_err), 1);
      check("len_abort_busy", 32'(busy), 0);
      repeat (2) begin
        junk = 8'($urandom);
        if (junk == PREFIX) junk = 8'h00;
        send_byte(junk);
        check("len_junk_busy", 32'(busy), 0);
      end
      return;
    end
    check("len_ok", 32'(len_err), 0);
    foreach (pl[i]) begin
      gap();
      send_byte(pl[i]);
    end
    gap(); send_byte(sum + crc_delta);
    if (crc_delta != 8'h00) begin
      exp_crc++;
      check("crc_err", 32'(crc_err), 1);
      check("crc_busy", 32'(busy), 0);
      step(); step();
      check("crc_no_valid", 32'(valid_bus), 0);
      return;
    end
    check("crc_ok", 32'(crc_err), 0);
    if (int'(dst) >= N_SRC) begin
      exp_addr++;
      check("addr_err", 32'(addr_err), 1);
      check("addr_busy", 32'(busy), 0);
      return;
    end
    check("addr_ok", 32'(addr_err), 0);
    exp_src = src;
    check("src_update", 32'(src_addr), 32'(exp_src));
    if (len == 8'd0) begin
      check("len0_busy", 32'(busy), 0);
      step();
      check("len0_no_valid", 32'(valid_bus), 0);
      return;
    end
    drain(dst, pl, ready_pct);
  endtask

  initial begin
    logic [7:0] pl[$];
    logic [7:0] src, dst, len, delta, b;
    int r, pct, j;

    repeat (3) step();
    check("rst_master_data", 32'(master_data), 0);
    check("rst_valid_bus", 32'(valid_bus), 0);
    check("rst_src_addr", 32'(src_addr), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_errs", 32'({crc_err, len_err, addr_err, drop_err, tmo_err}), 0);
    n_rst = 1'b1;
    step();

    pl.delete();
    for (int i = 1; i <= 6; i++) pl.push_back(8'(i));
    run_frame(8'h01, 8'h00, 8'h06, pl, 8'h00, 100);
    check("tp1_src", 32'(src_addr), 32'h01);

    run_frame(8'h01, 8'h00, 8'h06, pl, 8'hF9, 100);
    check("tp2_src_kept", 32'(src_addr), 32'h01);

    pl.delete();
    run_frame(8'h02, 8'h03, 8'h00, pl, 8'h00, 100);
    check("tp3_src", 32'(src_addr), 32'h02);
    pl.push_back(8'hAA);
    run_frame(8'h02, 8'h09, 8'h01, pl, 8'h00, 100);
    pl.delete();
    run_frame(8'h01, 8'h00, 8'h21, pl, 8'h00, 100);
    check("tp4_src_kept", 32'(src_addr), 32'h02);

    pl.delete();
    pl.push_back(8'h5A); pl.push_back(8'hDD); pl.push_back(8'h3C);
    rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    inject_at = 2;
    run_frame(8'h07, 8'h02, 8'h03, pl, 8'h00, 100);
    rdy_pat.delete();
    inject_at = -1;

`ifdef PARSER_TIMEOUT_EN
    send_byte(PREFIX);
    send_byte(8'h01);
    j = 0;
    while (!tmo_err && j < TIMEOUT_CYC + 10) begin
      step();
      j++;
    end
    exp_tmo++;
    check("tmo_latency", 32'(j), 32'(TIMEOUT_CYC));
    check("tmo_busy", 32'(busy), 0);
    pl.delete();
    pl.push_back(8'h10); pl.push_back(8'h20);
    run_frame(8'h04, 8'h05, 8'h02, pl, 8'h00, 100);
`else
    send_byte(PREFIX);
    send_byte(8'h01);
    repeat (TIMEOUT_CYC + 20) step();
    check("stall_busy", 32'(busy), 1);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h01);
    exp_src = 8'h01;
    check("stall_frame_src", 32'(src_addr), 32'(exp_src));
    check("stall_frame_busy", 32'(busy), 0);
`endif

    for (int f = 0; f < 30; f++) begin
      repeat ($urandom_range(2)) begin
        b = 8'($urandom);
        if (b == PREFIX) b = 8'h00;
        send_byte(b);
      end
      check("noise_busy", 32'(busy), 0);
      src = 8'($urandom);
      dst = 8'($urandom_range(9));
      r = int'($urandom_range(99));
      if (r < 10)      len = 8'd0;
      else if (r < 20) len = 8'(MAX_LEN + 1 + int'($urandom_range(5)));
      else if (r < 25) len = 8'(MAX_LEN);
      else             len = 8'($urandom_range(12, 1));
      pl.delete();
      if (int'(len) <= MAX_LEN) for (int i = 0; i < int'(len); i++) pl.push_back(8'($urandom));
      delta = ($urandom_range(99) < 20) ? 8'($urandom_range(255, 1)) : 8'h00;
      gap_max = int'($urandom_range(2));
      pct = int'($urandom_range(100, 30));
      run_frame(src, dst, len, pl, delta, pct);
      check("rand_src_addr", 32'(src_addr), 32'(exp_src));
    end
    gap_max = 0;

    // Reset while a frame is being offered: valid must drop at once.
    pl.delete();
    pl.push_back(8'h11); pl.push_back(8'h22); pl.push_back(8'h33);
    dest_ready = '0;
    send_byte(PREFIX);
    send_byte(8'h05); send_byte(8'h04); send_byte(8'h03);
    foreach (pl[i]) send_byte(pl[i]);
    send_byte(8'h72);
    step(); step(); step();
    check("pre_rst_valid", 32'(valid_bus), 32'h10);
    #2 n_rst = 1'b0;
    #1;
    check("async_rst_valid", 32'(valid_bus), 0);
    check("async_rst_busy", 32'(busy), 0);
    check("async_rst_src", 32'(src_addr), 0);
    exp_src = 8'h00;
    step(); step();
    n_rst = 1'b1;
    step();
    run_frame(8'h09, 8'h06, 8'h03, pl, 8'h00, 100);

    step(); step();
    check("tot_crc_err", 32'(seen_crc), 32'(exp_crc));
    check("tot_len_err", 32'(seen_len), 32'(exp_len));
    check("tot_addr_err", 32'(seen_addr), 32'(exp_addr));
    check("tot_drop_err", 32'(seen_drop), 32'(exp_drop));
    check("tot_tmo_err", 32'(seen_tmo), 32'(exp_tmo));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
